// File: rtl/tf_rom_ctrl_pkg.sv
// Shared definitions for the twiddle-factor ROM sequencer: FSM encodings, transform modes
// and the per-stage read count helper.
package tf_rom_ctrl_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  // ROM reads per stage: each read feeds BFU butterflies, two points each.
  function automatic int unsigned calc_cyc(input int unsigned log_n, input int unsigned bfu);
    return (32'd1 << log_n) / (2 * bfu);
  endfunction

endpackage

// File: rtl/tf_rom_ctrl_if.sv
// Host load handshake plus twiddle ROM pins. Signal suffixes are from the sequencer's view;
// the sequencer takes the master modport, the host/ROM side takes slave.
interface tf_rom_ctrl_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 56
);

  logic              ld_valid_i;
  logic [DATA_W-1:0] ld_data_i;
  logic              ld_ready_o;
  logic              rom_en_o;
  logic              rom_ren_o;
  logic [ADDR_W-1:0] rom_a_o;
  logic [DATA_W-1:0] rom_d_o;

  modport master (
    input  ld_valid_i, ld_data_i,
    output ld_ready_o, rom_en_o, rom_ren_o, rom_a_o, rom_d_o
  );

  modport slave (
    output ld_valid_i, ld_data_i,
    input  ld_ready_o, rom_en_o, rom_ren_o, rom_a_o, rom_d_o
  );

endinterface

// File: rtl/tf_addr_gen.sv
// Stage/cycle counters for the RUN read sequence: latches the table select on init, advances
// on each issued read and flags the final read of the transform.
module tf_addr_gen
  import tf_rom_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned LOG_N     = 6,
  parameter int unsigned BFU       = 4,
  parameter int unsigned NTT_BASE  = 0,
  parameter int unsigned INTT_BASE = 192,
  parameter int unsigned STG_W     = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  input  logic              mode_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [STG_W-1:0]  stg_o,
  output logic              last_o
);

  localparam int unsigned Cyc  = calc_cyc(LOG_N, BFU);
  localparam int unsigned CycW = (Cyc > 1) ? $clog2(Cyc) : 1;

  logic              r_mode;
  logic [STG_W-1:0]  r_stg;
  logic [CycW-1:0]   r_cyc;
  logic              w_cyc_last;
  logic              w_stg_last;
  logic [ADDR_W-1:0] w_base;

  assign w_cyc_last = (r_cyc == CycW'(Cyc - 1));
  assign w_stg_last = (r_stg == STG_W'(LOG_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_NTT;
      r_stg  <= '0;
      r_cyc  <= '0;
    end else if (init_i) begin
      r_mode <= mode_i;
      r_stg  <= '0;
      r_cyc  <= '0;
    end else if (adv_i) begin
      if (w_cyc_last) begin
        r_cyc <= '0;
        r_stg <= w_stg_last ? '0 : r_stg + STG_W'(1);
      end else begin
        r_cyc <= r_cyc + CycW'(1);
      end
    end
  end

  assign w_base = (r_mode == MODE_INTT) ? ADDR_W'(INTT_BASE) : ADDR_W'(NTT_BASE);
  assign addr_o = w_base + ADDR_W'(r_stg) * ADDR_W'(Cyc) + ADDR_W'(r_cyc);
  assign stg_o  = r_stg;
  assign last_o = w_stg_last && w_cyc_last;

endmodule

// File: rtl/tf_rom_ctrl.sv
// Twiddle-factor ROM sequencer for the 4-BFU NTT core: optional host load (TF_ROM_LOAD_EN)
// and one ROM read per butterfly cycle, with valid/stage/done aligned to the registered Q.
module tf_rom_ctrl
  import tf_rom_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 56,
  parameter int unsigned DEPTH     = 383,
  parameter int unsigned LOG_N     = 6,
  parameter int unsigned BFU       = 4,
  parameter int unsigned NTT_BASE  = 0,
  parameter int unsigned INTT_BASE = 192,
  parameter int unsigned STG_W     = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic             stall_i,
  tf_rom_ctrl_if.master    bus,
  output logic             tf_valid_o,
  output logic [STG_W-1:0] tf_stage_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned Cyc = calc_cyc(LOG_N, BFU);

  if ((NTT_BASE + LOG_N * Cyc > DEPTH) || (INTT_BASE + LOG_N * Cyc > DEPTH)) begin : g_tbl_chk
    $error("twiddle table does not fit in ROM depth");
  end

  logic [1:0]        r_state;
  logic [1:0]        w_state;
  logic              w_rd;
  logic              w_wr;
  logic              w_start;
  logic              w_last;
  logic [ADDR_W-1:0] w_gen_addr;
  logic [STG_W-1:0]  w_gen_stg;
  logic              r_tf_valid;
  logic [STG_W-1:0]  r_tf_stage;
  logic              r_done;

  assign w_rd = (r_state == StRun) && !stall_i;

  tf_addr_gen #(
    .ADDR_W    (ADDR_W),
    .LOG_N     (LOG_N),
    .BFU       (BFU),
    .NTT_BASE  (NTT_BASE),
    .INTT_BASE (INTT_BASE),
    .STG_W     (STG_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .init_i (w_start),
    .mode_i (mode_i),
    .adv_i  (w_rd),
    .addr_o (w_gen_addr),
    .stg_o  (w_gen_stg),
    .last_o (w_last)
  );

`ifdef TF_ROM_LOAD_EN
  logic [ADDR_W-1:0] r_ld_ptr;
  logic              w_ptr_last;

  // Ready is gated by reset so the pins read all-zero while rst_n is held low.
  assign bus.ld_ready_o = rst_n && (r_state != StRun);
  assign w_wr           = bus.ld_valid_i && bus.ld_ready_o;
  assign w_ptr_last     = (r_ld_ptr == ADDR_W'(DEPTH - 1));
  assign w_start        = (r_state == StIdle) && start_i && !bus.ld_valid_i;
  assign bus.rom_ren_o  = !w_wr;
  assign bus.rom_d_o    = w_wr ? bus.ld_data_i : {DATA_W{1'b0}};
  assign bus.rom_a_o    = w_wr ? r_ld_ptr : ((r_state == StRun) ? w_gen_addr : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_ptr <= '0;
    end else if (w_wr) begin
      r_ld_ptr <= w_ptr_last ? '0 : r_ld_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state = r_state;
    case (r_state)
      StIdle: begin
        if (w_wr) begin
          w_state = w_ptr_last ? StIdle : StLoad;
        end else if (w_start) begin
          w_state = StRun;
        end
      end
      StLoad: if (w_wr && w_ptr_last) w_state = StIdle;
      StRun:  if (w_rd && w_last) w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end
`else
  logic w_unused;

  assign w_unused       = ^{bus.ld_valid_i, bus.ld_data_i};
  assign bus.ld_ready_o = 1'b0;
  assign w_wr           = 1'b0;
  assign w_start        = (r_state == StIdle) && start_i;
  assign bus.rom_ren_o  = 1'b1;
  assign bus.rom_d_o    = {DATA_W{1'b0}};
  assign bus.rom_a_o    = (r_state == StRun) ? w_gen_addr : '0;

  always_comb begin
    w_state = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state = StRun;
      StRun:   if (w_rd && w_last) w_state = StIdle;
      default: w_state = StIdle;
    endcase
  end
`endif

  assign bus.rom_en_o = w_wr || w_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_tf_valid <= 1'b0;
      r_tf_stage <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_tf_valid <= w_rd;
      r_tf_stage <= w_rd ? w_gen_stg : '0;
      r_done     <= w_rd && w_last;
    end
  end

  assign tf_valid_o = r_tf_valid;
  assign tf_stage_o = r_tf_stage;
  assign done_o     = r_done;
  assign busy_o     = (r_state != StIdle);

endmodule

// File: tb/tb_tf_rom_ctrl.sv
// Directed bench for tf_rom_ctrl; expectations follow TF_ROM_LOAD_EN as defined for the build.
module tb_tf_rom_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       mode_i;
  logic       stall_i;
  logic       tf_valid_o;
  logic [2:0] tf_stage_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tf_rom_ctrl_if #(.ADDR_W(9), .DATA_W(56)) bus ();

  tf_rom_ctrl #(
    .ADDR_W    (9),
    .DATA_W    (56),
    .DEPTH     (383),
    .LOG_N     (6),
    .BFU       (4),
    .NTT_BASE  (0),
    .INTT_BASE (192)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .mode_i     (mode_i),
    .stall_i    (stall_i),
    .bus        (bus),
    .tf_valid_o (tf_valid_o),
    .tf_stage_o (tf_stage_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] wd(input int i);
    return {14'(i), 14'(i) ^ 14'h2AAA, ~14'(i), 14'(i) + 14'h1357};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en"}, 64'(bus.rom_en_o), 64'(0));
    chk({tag, "_ren"}, 64'(bus.rom_ren_o), 64'(1));
    chk({tag, "_d"}, 64'(bus.rom_d_o), 64'(0));
    chk({tag, "_valid"}, 64'(tf_valid_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
  endtask

  // Full 383-word load; optional idle gaps and a start_i collision on the first word.
  task automatic do_load(input bit toggle, input bit with_start);
    for (int i = 0; i < 383; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = wd(i);
      start_i        = with_start && (i == 0);
      mode_i         = 1'b0;
      #1;
      chk("ld_en", 64'(bus.rom_en_o), 64'(1));
      chk("ld_ren", 64'(bus.rom_ren_o), 64'(0));
      chk("ld_addr", 64'(bus.rom_a_o), 64'(i));
      chk("ld_data", 64'(bus.rom_d_o), 64'(wd(i)));
      chk("ld_ready", 64'(bus.ld_ready_o), 64'(1));
      chk("ld_no_valid", 64'(tf_valid_o), 64'(0));
      chk("ld_no_done", 64'(done_o), 64'(0));
      next_cycle();
      start_i = 1'b0;
      chk("ld_busy", 64'(busy_o), 64'(i != 382));
      if (toggle && (i % 2 == 0)) begin
        bus.ld_valid_i = 1'b0;
        bus.ld_data_i  = wd(i + 1000);
        #1;
        chk("ld_gap_en", 64'(bus.rom_en_o), 64'(0));
        chk("ld_gap_d", 64'(bus.rom_d_o), 64'(0));
        next_cycle();
      end
    end
    bus.ld_valid_i = 1'b0;
    #1;
    chk_quiet("ld_end");
    chk("ld_end_busy", 64'(busy_o), 64'(0));
    next_cycle();
  endtask

  // One transform; start_i/ld_valid_i are poked mid-run and must have no effect.
  task automatic do_run(input bit mode, input int stall_at, input int stall_len, input bit with_ld);
    int  k     = 0;
    int  n     = 0;
    int  left  = stall_len;
    int  base  = mode ? 192 : 0;
    bit  pv    = 1'b0;
    int  ps    = 0;
    bit  stall;
    start_i        = 1'b1;
    mode_i         = mode;
    bus.ld_valid_i = with_ld;
    bus.ld_data_i  = wd(7);
    #1;
    chk("st_en", 64'(bus.rom_en_o), 64'(0));
    chk("st_busy", 64'(busy_o), 64'(0));
    next_cycle();
    while (k < 48 && n < 200) begin
      stall          = (k == stall_at) && (left > 0);
      stall_i        = stall;
      start_i        = (k == 5);
      mode_i         = ~mode;
      bus.ld_valid_i = (k == 7);
      #1;
      chk("run_en", 64'(bus.rom_en_o), 64'(!stall));
      chk("run_ren", 64'(bus.rom_ren_o), 64'(1));
      chk("run_addr", 64'(bus.rom_a_o), 64'(base + k));
      chk("run_d", 64'(bus.rom_d_o), 64'(0));
      chk("run_ready", 64'(bus.ld_ready_o), 64'(0));
      chk("run_busy", 64'(busy_o), 64'(1));
      chk("run_valid", 64'(tf_valid_o), 64'(pv));
      if (pv) chk("run_stage", 64'(tf_stage_o), 64'(ps));
      chk("run_done", 64'(done_o), 64'(0));
      pv = !stall;
      ps = k / 8;
      if (stall) left--;
      else k++;
      n++;
      next_cycle();
    end
    chk("run_count", 64'(k), 64'(48));
    chk("run_cycles", 64'(n), 64'(48 + stall_len));
    stall_i        = 1'b0;
    start_i        = 1'b0;
    bus.ld_valid_i = 1'b0;
    #1;
    chk("fin_valid", 64'(tf_valid_o), 64'(1));
    chk("fin_stage", 64'(tf_stage_o), 64'(5));
    chk("fin_done", 64'(done_o), 64'(1));
    chk("fin_en", 64'(bus.rom_en_o), 64'(0));
    chk("fin_busy", 64'(busy_o), 64'(0));
    next_cycle();
    chk_quiet("post");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start_i        = 1'b0;
    mode_i         = 1'b0;
    stall_i        = 1'b0;
    bus.ld_valid_i = 1'b0;
    bus.ld_data_i  = '0;
    #2;
    chk_quiet("rst");
    chk("rst_addr", 64'(bus.rom_a_o), 64'(0));
    chk("rst_ready", 64'(bus.ld_ready_o), 64'(0));
    chk("rst_stage", 64'(tf_stage_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk_quiet("idle");
      chk("idle_busy", 64'(busy_o), 64'(0));
`ifdef TF_ROM_LOAD_EN
      chk("idle_ready", 64'(bus.ld_ready_o), 64'(1));
`else
      chk("idle_ready", 64'(bus.ld_ready_o), 64'(0));
`endif
      next_cycle();
    end

`ifdef TF_ROM_LOAD_EN
    do_load(1'b1, 1'b0);
    do_load(1'b0, 1'b0);
`else
    for (int i = 0; i < 8; i++) begin
      bus.ld_valid_i = i[0];
      bus.ld_data_i  = wd(i);
      #1;
      chk_quiet("noload");
      chk("noload_ready", 64'(bus.ld_ready_o), 64'(0));
      next_cycle();
      chk("noload_busy", 64'(busy_o), 64'(0));
    end
    bus.ld_valid_i = 1'b0;
`endif

    do_run(1'b0, -1, 0, 1'b0);
    do_run(1'b1, 10, 3, 1'b0);

`ifdef TF_ROM_LOAD_EN
    do_load(1'b0, 1'b1);
`else
    do_run(1'b0, -1, 0, 1'b1);
`endif

    // Reset while address 20 of an NTT is on the pins.
    start_i = 1'b1;
    mode_i  = 1'b0;
    next_cycle();
    start_i = 1'b0;
    for (int k = 0; k < 20; k++) next_cycle();
    #1;
    chk("pre_rst_addr", 64'(bus.rom_a_o), 64'(20));
    chk("pre_rst_valid", 64'(tf_valid_o), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(tf_valid_o), 64'(0));
    chk("mid_rst_done", 64'(done_o), 64'(0));
    chk("mid_rst_busy", 64'(busy_o), 64'(0));
    chk("mid_rst_en", 64'(bus.rom_en_o), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      chk_quiet("after_rst");
      chk("after_rst_busy", 64'(busy_o), 64'(0));
      next_cycle();
    end

    do_run(1'b0, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
